load_data_decoder: RTL and testbench

- Load-side counterpart of the store data encoder. Captures load request attributes (byte offset, access size, signedness, destination register) when the address is issued to synchronous data memory.
- Pipelines those attributes alongside the memory read latency. When the read word returns, extracts the addressed byte or halfword, then zero- or sign-extends it.
- Sits between data memory read port and the register writeback stage. Produces a registered, validated load result with a misalignment flag.

---
 rtl/load_data_decoder.sv | 150 +++++++++++++++
 tb/tb_load_data_decoder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_data_decoder.sv
// Load-side data decoder: tracks load attributes across the memory read latency,
// then extracts and zero/sign-extends the addressed byte or halfword of mem_rdata.
module load_data_decoder #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned RD_W        = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [1:0]      req_offset,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [RD_W-1:0] req_rd,
    input  logic            flush,
    input  logic [31:0]     mem_rdata,
    output logic            out_valid,
    output logic [31:0]     out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_err
);

    // Stage 0 captures the request; the final stage lines up with the returning mem_rdata.
    localparam int unsigned DEPTH = MEM_LATENCY + 1;
    localparam int unsigned LAST  = DEPTH - 1;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] sgn_q, sgn_d;
    logic [1:0]       off_q  [DEPTH];
    logic [1:0]       off_d  [DEPTH];
    size_e            size_q [DEPTH];
    size_e            size_d [DEPTH];
    logic [RD_W-1:0]  rd_q   [DEPTH];
    logic [RD_W-1:0]  rd_d   [DEPTH];

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [RD_W-1:0]  out_rd_q, out_rd_d;
    logic             out_err_q, out_err_d;

    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [31:0]      ext_c;
    logic             mis_c;

    // Attribute shift register; flush kills every stage plus the incoming request.
    always_comb begin
        vld_d     = '0;
        sgn_d     = {sgn_q[DEPTH-2:0], req_signed};
        off_d[0]  = req_offset;
        size_d[0] = size_e'(req_size);
        rd_d[0]   = req_rd;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            off_d[i]  = off_q[i-1];
            size_d[i] = size_q[i-1];
            rd_d[i]   = rd_q[i-1];
        end
        if (!flush) begin
            vld_d = {vld_q[DEPTH-2:0], req_valid};
        end
    end

    // Big-endian lane select and extension for the request in the final stage.
    always_comb begin
        byte_c = mem_rdata[7:0];
        case (off_q[LAST])
            2'd0:    byte_c = mem_rdata[31:24];
            2'd1:    byte_c = mem_rdata[23:16];
            2'd2:    byte_c = mem_rdata[15:8];
            default: byte_c = mem_rdata[7:0];
        endcase
        half_c = off_q[LAST][1] ? mem_rdata[15:0] : mem_rdata[31:16];

        mis_c = 1'b0;
        ext_c = mem_rdata;
        case (size_q[LAST])
            SZ_WORD: begin
                mis_c = (off_q[LAST] != 2'd0);
                ext_c = mem_rdata;
            end
            SZ_HALF: begin
                mis_c = off_q[LAST][0];
                ext_c = {{16{sgn_q[LAST] & half_c[15]}}, half_c};
            end
            SZ_BYTE: begin
                ext_c = {{24{sgn_q[LAST] & byte_c[7]}}, byte_c};
            end
            default: begin
                mis_c = 1'b1;
            end
        endcase
        if (mis_c) begin
            ext_c = '0;
        end
    end

    // Result register; data and tag hold between results.
    always_comb begin
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
        if (vld_q[LAST] && !flush) begin
            out_valid_d = 1'b1;
            out_err_d   = mis_c;
            out_data_d  = ext_c;
            out_rd_d    = rd_q[LAST];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            sgn_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                off_q[i]  <= 2'd0;
                size_q[i] <= SZ_WORD;
                rd_q[i]   <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            sgn_q       <= sgn_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                off_q[i]  <= off_d[i];
                size_q[i] <= size_d[i];
                rd_q[i]   <= rd_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_load_data_decoder.sv
// Bench for load_data_decoder: two instances (latency 1 and 3) on shared stimulus,
// checked each cycle against a history-based reference plus directed scenarios.
module tb_load_data_decoder;

    localparam int unsigned RD_W = 5;
    localparam int NH = 4096;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic [1:0]      req_offset = 2'd0;
    logic [1:0]      req_size = 2'd0;
    logic            req_signed = 1'b0;
    logic [RD_W-1:0] req_rd = '0;
    logic            flush = 1'b0;
    logic [31:0]     mem_rdata = '0;

    logic            o1_valid, o1_err, o3_valid, o3_err;
    logic [31:0]     o1_data, o3_data;
    logic [RD_W-1:0] o1_rd, o3_rd;

    load_data_decoder #(.MEM_LATENCY(1), .RD_W(RD_W)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_offset(req_offset),
        .req_size(req_size), .req_signed(req_signed), .req_rd(req_rd), .flush(flush),
        .mem_rdata(mem_rdata), .out_valid(o1_valid), .out_data(o1_data),
        .out_rd(o1_rd), .out_err(o1_err)
    );

    load_data_decoder #(.MEM_LATENCY(3), .RD_W(RD_W)) u3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_offset(req_offset),
        .req_size(req_size), .req_signed(req_signed), .req_rd(req_rd), .flush(flush),
        .mem_rdata(mem_rdata), .out_valid(o3_valid), .out_data(o3_data),
        .out_rd(o3_rd), .out_err(o3_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     d;
        logic [RD_W-1:0] r;
        logic            e;
        int              c;
    } res_t;

    res_t log1[$];
    res_t log3[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rst_floor = 0;

    bit              h_req   [NH];
    logic [1:0]      h_off   [NH];
    logic [1:0]      h_size  [NH];
    bit              h_sgn   [NH];
    logic [RD_W-1:0] h_rd    [NH];
    bit              h_flush [NH];
    logic [31:0]     h_rdata [NH];

    logic [31:0]     l1_d = '0, l3_d = '0;
    logic [RD_W-1:0] l1_rd = '0, l3_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_err(input logic [1:0] off, input logic [1:0] size);
        return (size == 2'd3) || (size == 2'd0 && off != 2'd0) || (size == 2'd1 && off[0]);
    endfunction

    // Extraction by plain shifting and two's-complement arithmetic.
    function automatic logic [31:0] ref_data(input logic [1:0] off, input logic [1:0] size,
                                             input bit sgn, input logic [31:0] w);
        logic [31:0] f;
        if (ref_err(off, size)) return 32'h0;
        if (size == 2'd0) return w;
        if (size == 2'd1) begin
            f = (w >> (16 * (1 - int'(off) / 2))) & 32'h0000FFFF;
            if (sgn && f >= 32'h8000) f = f - 32'h10000;
        end else begin
            f = (w >> (8 * (3 - int'(off)))) & 32'h000000FF;
            if (sgn && f >= 32'h80) f = f - 32'h100;
        end
        return f;
    endfunction

    // Result at edge c comes from the request sampled at edge c-L-1 and mem_rdata sampled at c.
    task automatic expect_at(input int c, input int lat, output bit ev, output bit ee,
                             output logic [31:0] ed, output logic [RD_W-1:0] er);
        int src;
        src = c - lat - 1;
        ev = 1'b0; ee = 1'b0; ed = '0; er = '0;
        if (src >= 1 && src >= rst_floor && h_req[src]) begin
            ev = 1'b1;
            for (int k = src; k <= c; k++) if (h_flush[k]) ev = 1'b0;
        end
        if (ev) begin
            ee = ref_err(h_off[src], h_size[src]);
            ed = ref_data(h_off[src], h_size[src], h_sgn[src], h_rdata[c]);
            er = h_rd[src];
        end
    endtask

    always @(posedge rst) begin
        rst_floor = cyc + 1;
        l1_d = '0; l1_rd = '0; l3_d = '0; l3_rd = '0;
    end

    always @(posedge clk) begin
        bit              ev, ee;
        logic [31:0]     ed;
        logic [RD_W-1:0] er;
        cyc++;
        h_req[cyc]   = req_valid && !rst;
        h_off[cyc]   = req_offset;
        h_size[cyc]  = req_size;
        h_sgn[cyc]   = req_signed;
        h_rd[cyc]    = req_rd;
        h_flush[cyc] = flush;
        h_rdata[cyc] = mem_rdata;
        #1;
        if (rst) begin
            chk("rst_valid", 32'({o1_valid, o3_valid}), 32'h0);
            chk("rst_err", 32'({o1_err, o3_err}), 32'h0);
            chk("rst_data", o1_data | o3_data, 32'h0);
            chk("rst_rd", 32'(o1_rd | o3_rd), 32'h0);
        end else begin
            expect_at(cyc, 1, ev, ee, ed, er);
            if (ev) begin l1_d = ed; l1_rd = er; end
            chk("l1_valid", 32'(o1_valid), 32'(ev));
            chk("l1_err", 32'(o1_err), 32'(ee));
            chk("l1_data", o1_data, l1_d);
            chk("l1_rd", 32'(o1_rd), 32'(l1_rd));
            expect_at(cyc, 3, ev, ee, ed, er);
            if (ev) begin l3_d = ed; l3_rd = er; end
            chk("l3_valid", 32'(o3_valid), 32'(ev));
            chk("l3_err", 32'(o3_err), 32'(ee));
            chk("l3_data", o3_data, l3_d);
            chk("l3_rd", 32'(o3_rd), 32'(l3_rd));
        end
        if (o1_valid) log1.push_back('{o1_data, o1_rd, o1_err, cyc});
        if (o3_valid) log3.push_back('{o3_data, o3_rd, o3_err, cyc});
    end

    // Drives one request at the current negedge; returns the edge index that samples it.
    task automatic drive(input bit v, input logic [1:0] off, input logic [1:0] size,
                         input bit sgn, input logic [RD_W-1:0] rd, input bit fl, output int t);
        req_valid = v; req_offset = off; req_size = size; req_signed = sgn;
        req_rd = rd; flush = fl;
        t = cyc + 1;
    endtask

    task automatic idle();
        req_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        int t, t0;
        logic [31:0] exp_b [4];
        logic [31:0] exp_h [3];
        logic [1:0]  h_offs [3];
        bit          h_sgns [3];
        logic [1:0]  e_off [3];
        logic [1:0]  e_size [3];

        exp_b = '{32'hFFFFFF88, 32'h00000099, 32'hFFFFFFAA, 32'h000000BB};
        exp_h = '{32'h00008899, 32'hFFFFAABB, 32'h0000AABB};
        h_offs = '{2'd0, 2'd2, 2'd2};
        h_sgns = '{1'b0, 1'b1, 1'b0};
        e_off  = '{2'd1, 2'd2, 2'd0};
        e_size = '{2'd1, 2'd0, 2'd3};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        mem_rdata = 32'h8899AABB;
        @(negedge clk);

        // Aligned word, latency 1
        log1.delete();
        drive(1'b1, 2'd0, 2'd0, 1'b0, 5'd7, 1'b0, t);
        @(negedge clk); idle();
        repeat (4) @(negedge clk);
        chk("word_count", 32'(log1.size()), 32'd1);
        if (log1.size() > 0) begin
            chk("word_data", log1[0].d, 32'h8899AABB);
            chk("word_rd", 32'(log1[0].r), 32'd7);
            chk("word_err", 32'(log1[0].e), 32'd0);
            chk("word_lat", 32'(log1[0].c), 32'(t + 2));
        end

        // Back-to-back bytes
        log1.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 2'd2, (i % 2) == 0, 5'(i + 1), 1'b0, t);
            if (i == 0) t0 = t;
            @(negedge clk);
        end
        idle();
        repeat (5) @(negedge clk);
        chk("byte_count", 32'(log1.size()), 32'd4);
        for (int i = 0; i < 4 && i < log1.size(); i++) begin
            chk("byte_data", log1[i].d, exp_b[i]);
            chk("byte_cycle", 32'(log1[i].c), 32'(t0 + 2 + i));
        end

        // Halves
        log1.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, h_offs[i], 2'd1, h_sgns[i], 5'(10 + i), 1'b0, t);
            @(negedge clk);
        end
        idle();
        repeat (5) @(negedge clk);
        chk("half_count", 32'(log1.size()), 32'd3);
        for (int i = 0; i < 3 && i < log1.size(); i++) chk("half_data", log1[i].d, exp_h[i]);

        // Misaligned and reserved
        log1.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, e_off[i], e_size[i], 1'b1, 5'(20 + i), 1'b0, t);
            @(negedge clk);
        end
        idle();
        repeat (5) @(negedge clk);
        chk("err_count", 32'(log1.size()), 32'd3);
        for (int i = 0; i < 3 && i < log1.size(); i++) begin
            chk("err_flag", 32'(log1[i].e), 32'd1);
            chk("err_data", log1[i].d, 32'h0);
            chk("err_rd", 32'(log1[i].r), 32'(20 + i));
        end

        // Flush with latency 3
        log3.delete();
        drive(1'b1, 2'd0, 2'd0, 1'b0, 5'd1, 1'b0, t); @(negedge clk);
        drive(1'b1, 2'd1, 2'd2, 1'b1, 5'd2, 1'b0, t); @(negedge clk);
        drive(1'b1, 2'd2, 2'd2, 1'b1, 5'd3, 1'b1, t); @(negedge clk);
        drive(1'b1, 2'd3, 2'd2, 1'b0, 5'd9, 1'b0, t); @(negedge clk);
        idle();
        repeat (7) @(negedge clk);
        chk("flush_count", 32'(log3.size()), 32'd1);
        if (log3.size() > 0) begin
            chk("flush_lat", 32'(log3[0].c), 32'(t + 4));
            chk("flush_data", log3[0].d, 32'h000000BB);
            chk("flush_rd", 32'(log3[0].r), 32'd9);
        end

        // Async reset with two loads in flight
        drive(1'b1, 2'd0, 2'd2, 1'b1, 5'd4, 1'b0, t); @(negedge clk);
        drive(1'b1, 2'd1, 2'd2, 1'b1, 5'd5, 1'b0, t); @(negedge clk);
        idle();
        #2 rst = 1'b1;
        #1;
        chk("arst_data1", o1_data, 32'h0);
        chk("arst_rd1", 32'(o1_rd), 32'h0);
        chk("arst_data3", o3_data, 32'h0);
        chk("arst_rd3", 32'(o3_rd), 32'h0);
        chk("arst_valid", 32'({o1_valid, o3_valid}), 32'h0);
        log1.delete(); log3.delete();
        @(negedge clk); rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("arst_ghost1", 32'(log1.size()), 32'd0);
        chk("arst_ghost3", 32'(log3.size()), 32'd0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 9) < 7, 2'($urandom), 2'($urandom), 1'($urandom),
                  5'($urandom), $urandom_range(0, 19) == 0, t);
            mem_rdata = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        idle();
        repeat (6) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
